// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for fetch redirect sequencing, hazard unit and CP0 logic.
package fetch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    DRAIN  = 2'd2,
    VECTOR = 2'd3
  } fetch_state_e;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Control bundle between decode/hazard/trap sources and the fetch stage.
interface fetch_redirect_ctrl_if;
  logic        Hazard_Stall;
  logic        Branch_Req;
  logic [31:0] Branch_Target;
  logic        SYS;
  logic [31:0] SYS_PC;
  logic        STALL_2IF;
  logic        Request_Alt_PC;
  logic [31:0] Alt_PC;
  logic        Flush_ID;
  logic [31:0] EPC_OUT;
  logic        EPC_Valid;
  logic        Busy;

  modport master (
    output Hazard_Stall, Branch_Req, Branch_Target, SYS, SYS_PC,
    input  STALL_2IF, Request_Alt_PC, Alt_PC, Flush_ID, EPC_OUT, EPC_Valid, Busy
  );

  modport slave (
    input  Hazard_Stall, Branch_Req, Branch_Target, SYS, SYS_PC,
    output STALL_2IF, Request_Alt_PC, Alt_PC, Flush_ID, EPC_OUT, EPC_Valid, Busy
  );
endinterface

// File: rtl/fetch_drain_counter.sv
// 4-bit down-counter for multi-cycle fetch stalls; saturates at zero.
module fetch_drain_counter (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       zero
);

  // Load takes precedence over decrement; never decrements below zero.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                     count <= 4'd0;
    else if (load)                  count <= load_val;
    else if (dec && count != 4'd0)  count <= count - 4'd1;
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: merges branch redirects, hazard stalls and
// syscall trap entry into one per-cycle fetch command.
//
//   state  | meaning
//   RUN    | normal fetch, branches redirect immediately
//   HOLD   | branch arrived during a stall, target parked until stall clears
//   DRAIN  | syscall accepted, fetch frozen while pipeline empties
//   VECTOR | one cycle redirect to the exception vector, EPC published
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  fetch_redirect_ctrl_if.slave  bus
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
    $error("fetch_redirect_ctrl: DRAIN_CYCLES out of range 1..15");
  end

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pending_q;
  logic [31:0]  epc_q;
  logic         pend_load, pend_clear, epc_load;
  logic         cnt_load, cnt_dec, cnt_zero;
  logic [3:0]   cnt_count;

  fetch_drain_counter u_drain (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (cnt_load),
    .load_val (DRAIN_LOAD),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // State, parked branch target and captured trap PC.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= RUN;
      pending_q <= 32'd0;
      epc_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (pend_load)       pending_q <= bus.Branch_Target;
      else if (pend_clear) pending_q <= 32'd0;
      if (epc_load)        epc_q <= bus.SYS_PC;
    end
  end

  // Next state and combinational fetch command.
  always_comb begin
    state_d            = state_q;
    pend_load          = 1'b0;
    pend_clear         = 1'b0;
    epc_load           = 1'b0;
    cnt_load           = 1'b0;
    cnt_dec            = 1'b0;
    bus.STALL_2IF      = 1'b0;
    bus.Request_Alt_PC = 1'b0;
    bus.Alt_PC         = 32'd0;
    bus.Flush_ID       = 1'b0;
    bus.EPC_Valid      = 1'b0;
    case (state_q)
      RUN, HOLD: begin
        if (state_q == HOLD) begin
          bus.Alt_PC    = pending_q;
          bus.STALL_2IF = bus.Hazard_Stall;
        end
        if (bus.SYS) begin
          // Trap entry wins; a parked redirect is dropped. The accept cycle
          // is the first stalled cycle, so a 1-cycle drain vectors next.
          bus.STALL_2IF = 1'b1;
          bus.Flush_ID  = 1'b1;
          epc_load      = 1'b1;
          cnt_load      = 1'b1;
          pend_clear    = 1'b1;
          state_d       = (DRAIN_LOAD == 4'd0) ? VECTOR : DRAIN;
        end else if (state_q == HOLD) begin
          if (!bus.Hazard_Stall) begin
            bus.Request_Alt_PC = 1'b1;
            bus.Flush_ID       = 1'b1;
            pend_clear         = 1'b1;
            state_d            = RUN;
          end
        end else if (bus.Branch_Req && !bus.Hazard_Stall) begin
          bus.Request_Alt_PC = 1'b1;
          bus.Alt_PC         = bus.Branch_Target;
          bus.Flush_ID       = 1'b1;
        end else if (bus.Branch_Req) begin
          bus.STALL_2IF = 1'b1;
          pend_load     = 1'b1;
          state_d       = HOLD;
        end else begin
          bus.STALL_2IF = bus.Hazard_Stall;
        end
      end
      DRAIN: begin
        // Leave when this cycle's decrement reaches zero so that the accept
        // cycle plus DRAIN cycles totals exactly DRAIN_CYCLES stalls.
        bus.STALL_2IF = 1'b1;
        bus.Flush_ID  = 1'b1;
        cnt_dec       = 1'b1;
        if (cnt_zero || cnt_count == 4'd1) state_d = VECTOR;
      end
      VECTOR: begin
        bus.Request_Alt_PC = 1'b1;
        bus.Alt_PC         = EXC_VECTOR;
        bus.Flush_ID       = 1'b1;
        bus.EPC_Valid      = 1'b1;
        state_d            = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.EPC_OUT = epc_q;
  assign bus.Busy    = (state_q != RUN);

  // Fetch must never be told to stall and redirect at once.
  a_no_stall_and_redirect: assert property (@(posedge CLK) disable iff (!RESET)
    !(bus.Request_Alt_PC && bus.STALL_2IF));

  // EPC is only published on the vector cycle.
  a_epc_valid_in_vector: assert property (@(posedge CLK) disable iff (!RESET)
    bus.EPC_Valid |-> state_q == VECTOR);

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Sequences the fetch stage's control inputs: stall, alternate-PC request and alternate PC.
- Merges branch redirects from decode, hazard stalls and SYS (syscall) trap entry into one consistent per-cycle command to fetch.
- Holds a branch redirect that arrives during a stall so it is not lost.
- On SYS, drains the pipeline for a fixed number of cycles, then redirects fetch to the exception vector and records EPC.

Parameters:
DRAIN_CYCLES, 3, cycles fetch is held stalled after SYS accept before vectoring (legal range 1..15)
EXC_VECTOR, 32'hBFC00380, trap entry address driven on Alt_PC at vector time

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
Hazard_Stall  in  1  hazard unit requests fetch freeze this cycle
Branch_Req  in  1  decode resolved a taken branch/jump this cycle
Branch_Target  in  32  target for Branch_Req
SYS  in  1  decode holds a syscall this cycle
SYS_PC  in  32  address of the syscall instruction
STALL_2IF  out  1  fetch stall command
Request_Alt_PC  out  1  fetch loads Alt_PC instead of sequential PC
Alt_PC  out  32  redirect address
Flush_ID  out  1  squash instruction entering decode
EPC_OUT  out  32  captured trap PC
EPC_Valid  out  1  one-cycle pulse when EPC_OUT is updated and the vector is issued
Busy  out  1  state != RUN

Behaviour:
- Reset (async, RESET=0):
  - State=RUN; pending_target=0; drain count=0; EPC_OUT=0; EPC_Valid=0.
  - All combinational outputs evaluate to 0, Alt_PC=0.
  - Reset mid-drain or mid-hold aborts the operation: no vector is issued and no EPC_Valid pulse.
- States: RUN, HOLD, DRAIN, VECTOR.
- Outputs are combinational from state, registers and inputs. Request_Alt_PC and Alt_PC take effect in the same cycle they are asserted, because fetch consumes them combinationally.
- Priority, highest first: SYS, then Branch_Req, then sequential fetch.
- RUN:
  - SYS=1: latch EPC_OUT<=SYS_PC; count<=DRAIN_CYCLES-1; go DRAIN. STALL_2IF=1 and Flush_ID=1 in this cycle. Branch_Req is ignored.
  - else Branch_Req=1 and Hazard_Stall=0: Request_Alt_PC=1, Alt_PC=Branch_Target, Flush_ID=1; stay in RUN.
  - else Branch_Req=1 and Hazard_Stall=1: pending_target<=Branch_Target; STALL_2IF=1; go HOLD.
  - else: STALL_2IF=Hazard_Stall, all other outputs 0.
- HOLD:
  - STALL_2IF=Hazard_Stall. Alt_PC=pending_target whenever in HOLD.
  - Hazard_Stall=0: Request_Alt_PC=1, Flush_ID=1; go RUN.
  - Branch_Req in HOLD is ignored, because decode is frozen during a stall.
  - SYS in HOLD: discard the pending redirect and take the RUN SYS path.
- DRAIN:
  - STALL_2IF=1, Flush_ID=1. Branch_Req, SYS and Hazard_Stall are all ignored.
  - count decrements by 1 per cycle; when count==0, go VECTOR.
  - Net effect: exactly DRAIN_CYCLES stalled cycles, counting the accept cycle, before VECTOR.
- VECTOR (one cycle):
  - STALL_2IF=0, Request_Alt_PC=1, Alt_PC=EXC_VECTOR, Flush_ID=1, EPC_Valid=1; go RUN.
  - Hazard_Stall in VECTOR is overridden: the vector must issue.
- Counter: 4 bits, no wrap; it is never decremented below 0.
- Busy=1 in HOLD, DRAIN and VECTOR.
- Assertions:
  - Request_Alt_PC and STALL_2IF are never both 1.
  - EPC_Valid only in VECTOR.
  - DRAIN_CYCLES is within 1..15 (checked at elaboration).

Decomposition:
- Shared package: state encoding enum (RUN=0, HOLD=1, DRAIN=2, VECTOR=3) and the EXC_VECTOR default constant, both also used by the hazard unit and the CP0 logic.
- One sub-module: fetch_drain_counter (load, decrement, zero flag), reused later for other multi-cycle stalls.

Test Plan:
1. Reset release, no requests → STALL_2IF=0, Request_Alt_PC=0, Alt_PC=0, EPC_OUT=0, Busy=0 every cycle.
2. Branch_Req=1, Branch_Target=0xBFC00040, Hazard_Stall=0 → same cycle Request_Alt_PC=1, Alt_PC=0xBFC00040, Flush_ID=1; next cycle all 0.
3. Branch_Req with target 0xBFC00100 while Hazard_Stall=1, stall held 2 more cycles → STALL_2IF=1 for 3 cycles, Busy=1; in the first cycle Hazard_Stall=0, Request_Alt_PC=1 and Alt_PC=0xBFC00100.
4. SYS=1 with SYS_PC=0xBFC00020 and simultaneous Branch_Req → branch ignored; STALL_2IF=1 for 3 cycles; then one cycle of Request_Alt_PC=1, Alt_PC=0xBFC00380, EPC_Valid=1, EPC_OUT=0xBFC00020.
5. SYS during HOLD with pending 0xBFC00200 → 0xBFC00200 is never driven with Request_Alt_PC=1; the vector to 0xBFC00380 follows after 3 stalled cycles.
6. RESET=0 asserted in the second DRAIN cycle, then released → state RUN, EPC_Valid never pulses, EPC_OUT=0, STALL_2IF=0.
